// File: rtl/nios2_gen2_cpu_mult_pipe_if.sv
// Handshake and operand bundle for the pipelined multiplier.
// The master drives operands and out_ready; the slave returns in_ready, results and busy.
interface nios2_gen2_cpu_mult_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              signed_a;
    logic              signed_b;
    logic              hi_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output flush, in_valid, src1, src2, signed_a, signed_b, hi_sel, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, src1, src2, signed_a, signed_b, hi_sel, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/nios2_gen2_cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with per-operand signedness and hi/lo half select.
// LATENCY register stages, full-stall backpressure, synchronous flush, async active-high reset.
module nios2_gen2_cpu_mult_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input logic                       clk,
    input logic                       reset,
    nios2_gen2_cpu_mult_pipe_if.slave bus
);
    logic [LATENCY-1:0]  valid_q;
    logic [LATENCY-1:0]  valid_d;
    logic [DATA_W-1:0]   data_q [LATENCY];
    logic                advance;
    logic                load_en;
    logic [2*DATA_W-1:0] op_a;
    logic [2*DATA_W-1:0] op_b;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   prod_sel;

    // Extending to 2*DATA_W keeps the low 2*DATA_W product bits exact for either sign mode.
    always_comb begin
        op_a     = {{DATA_W{bus.signed_a & bus.src1[DATA_W-1]}}, bus.src1};
        op_b     = {{DATA_W{bus.signed_b & bus.src2[DATA_W-1]}}, bus.src2};
        prod     = op_a * op_b;
        prod_sel = bus.hi_sel ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
    end

    assign advance = !valid_q[LATENCY-1] || bus.out_ready;
    assign load_en = advance && !bus.flush;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = '0;
        end else if (advance) begin
            valid_d[0] = bus.in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Data only moves with a valid entry so idle stages keep their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (load_en && bus.in_valid) begin
                data_q[0] <= prod_sel;
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (load_en && valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[LATENCY-1];
    assign bus.result    = data_q[LATENCY-1];
    assign bus.busy      = |valid_q;
endmodule
